nibble_serial_addsub_ctrl: RTL and testbench
============================================

// Module: nibble_serial_addsub_ctrl
// PURPOSE
//   Sequencer for the shared 4-bit ripple adder/subtractor datapath. It adds or subtracts two
//   NIB*4-bit words by passing one nibble per clock through a single internally instantiated
//   4-bit add/sub core, LSB nibble first, and registers the carry between nibbles.
//   It sits between a requester using start/done and the arithmetic core, giving wide
//   arithmetic without replicating adders.
// PARAMETERS
//   NIB   4   number of nibbles per operand; operand width W = 4*NIB; legal range NIB >= 1
// PORTS
//   clk        in   1    single clock, all state updates on rising edge
//   reset      in   1    synchronous, active-high reset
//   start      in   1    request; sampled only in IDLE or DONE
//   op         in   1    0 = A+B, 1 = A-B (two's complement); latched with start
//   a          in   W    operand A; latched with start
//   b          in   W    operand B; latched with start
//   busy       out  1    high while in RUN
//   done       out  1    one-cycle pulse; result/flags valid from this cycle
//   result     out  W    sum/difference; held until the next accepted start
//   carry_out  out  1    carry out of the MSB (for subtraction, 1 = no borrow)
//   overflow   out  1    signed two's-complement overflow of the W-bit operation
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; internal regs cleared.
//   Reset mid-RUN aborts the operation: no done pulse, and outputs are forced to their reset values.
//   FSM: IDLE --start--> RUN; RUN --(idx==NIB-1)--> DONE; DONE --start--> RUN, else --> IDLE.
//   Accept (edge where start=1 and state is IDLE or DONE):
//     - latch a, b, op; set carry_reg=op; idx=0; state=RUN.
//   start is ignored while in RUN: no re-latch and no effect on the operation in flight.
//   RUN cycle idx (0..NIB-1): core inputs x=a_sh[3:0], y=b_sh[3:0], control=op, carryin=carry_reg.
//     - Core inverts y internally when op=1. The controller must not pre-invert.
//     - At the edge: a_sh/b_sh shift right by 4; the sum nibble shifts into result_sh from the MSB side.
//     - carry_reg takes the core carryout; idx increments.
//   Final nibble (idx==NIB-1), same edge:
//     - result <= completed word; carry_out <= core carryout.
//     - overflow <= (xa3 == yb3) && (s3 != xa3), where yb3 = b_sh[3]^op and s3 = core sum bit 3.
//     - state <= DONE.
//   Latency: if start is accepted at edge E, done=1 during the cycle after edge E+NIB.
//     busy=1 for exactly NIB cycles; done=1 for exactly 1 cycle.
//   Throughput: a start accepted in the DONE cycle begins a new RUN immediately,
//     giving one result every NIB+1 cycles. done is not re-asserted until that RUN finishes.
//   result/carry_out/overflow change only at the final-nibble edge or on reset. They stay
//     stable through DONE, IDLE and the whole next RUN. Partial sums are never visible.
//   NIB=1: RUN lasts one cycle, and the first RUN cycle is also the final nibble.
//   Width rules: all internal paths are W bits wide; the carry out of the MSB is dropped
//     from result and reported only on carry_out. idx is ceil(log2(NIB))+1 bits wide,
//     and 1 bit when NIB=1.
// TESTING
//   1 NIB=4, op=0, a=0x1234, b=0x0FFF
//       -> result=0x2233, carry_out=0, overflow=0.
//       -> done high exactly in the cycle after edge E+4; busy high for 4 cycles.
//   2 NIB=4, op=1, a=0x0005, b=0x0007
//       -> result=0xFFFE, carry_out=0 (borrow), overflow=0.
//   3 NIB=4, op=0, 0x7FFF+0x0001
//       -> result=0x8000, overflow=1, carry_out=0.
//     Then 0xFFFF+0x0001
//       -> result=0x0000, carry_out=1, overflow=0.
//   4 NIB=4, op=0, a=0x1111, b=0x2222; pulse start with a=0xFFFF in RUN cycle 2
//       -> ignored; result=0x3333.
//     Then start in the DONE cycle with 0x0001-0x0001
//       -> busy rises the next cycle; second done 5 cycles after the first; result=0x0000, carry_out=1.
//   5 Assert reset during RUN cycle 2 of any op
//       -> next cycle busy=0, done=0, result=0, flags=0; no done pulse follows.
//   6 NIB=1, op=1, a=0x7, b=0x8
//       -> result=0xF, overflow=1, carry_out=0; done in the cycle after edge E+1.

Source files
------------

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/result bundle for nibble_serial_addsub_ctrl.
//   master : requester side, drives start/op/a/b and observes status and result
//   slave  : controller side, samples the request and drives busy/done/result/flags
// NIB must match the NIB of the controller it is bound to (W = 4*NIB).
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIB = 4
) ();
  localparam int W = 4 * NIB;

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer.
// Adds or subtracts two W = 4*NIB bit words one nibble per clock through a
// single shared 4-bit add/sub core, LSB nibble first, carry registered
// between nibbles.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : slave modport of nibble_serial_addsub_ctrl_if
//            (start/op/a/b in; busy/done/result/carry_out/overflow out)

// 4-bit ripple add/sub core; control=1 inverts y so that with carryin=1 it
// computes x - y.
module nibble_addsub4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       control,
  input  logic       carryin,
  output logic [3:0] sum,
  output logic       carryout
);
  logic [3:0] y_eff;
  logic [4:0] full;

  assign y_eff    = y ^ {4{control}};
  assign full     = {1'b0, x} + {1'b0, y_eff} + {4'b0000, carryin};
  assign sum      = full[3:0];
  assign carryout = full[4];
endmodule

// state | meaning
// IDLE  | waiting for start, result/flags hold last value
// RUN   | one nibble processed per cycle, idx = nibble index
// DONE  | one-cycle done pulse; start here begins the next RUN at once
module nibble_serial_addsub_ctrl #(
  parameter int NIB = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  nibble_serial_addsub_ctrl_if.slave   bus
);
  localparam int W  = 4 * NIB;
  localparam int IW = (NIB == 1) ? 1 : $clog2(NIB) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh, result_sh, result_nxt;
  logic [W-1:0]  result_q;
  logic          op_r, carry_reg, carry_out_q, overflow_q;
  logic [IW-1:0] idx;
  logic          accept, last;
  logic [3:0]    core_sum;
  logic          core_co;

  nibble_addsub4 u_core (
    .x        (a_sh[3:0]),
    .y        (b_sh[3:0]),
    .control  (op_r),
    .carryin  (carry_reg),
    .sum      (core_sum),
    .carryout (core_co)
  );

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (idx == IW'(NIB - 1));

  // Sum nibble enters from the MSB side; after NIB shifts the word is complete.
  // Written as shift/or so it also holds for NIB=1 (W-4 = 0).
  assign result_nxt = (result_sh >> 4) | (W'(core_sum) << (W - 4));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh        <= '0;
      b_sh        <= '0;
      result_sh   <= '0;
      op_r        <= 1'b0;
      carry_reg   <= 1'b0;
      idx         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_sh      <= bus.a;
      b_sh      <= bus.b;
      op_r      <= bus.op;
      carry_reg <= bus.op;
      idx       <= '0;
      result_sh <= '0;
    end else if (state == RUN) begin
      a_sh      <= a_sh >> 4;
      b_sh      <= b_sh >> 4;
      result_sh <= result_nxt;
      carry_reg <= core_co;
      idx       <= idx + 1'b1;
      if (last) begin
        result_q    <= result_nxt;
        carry_out_q <= core_co;
        // Signed overflow: operands (after effective inversion) agree in sign
        // but the sum's sign differs.
        overflow_q  <= (a_sh[3] == (b_sh[3] ^ op_r)) && (core_sum[3] != a_sh[3]);
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
module tb_nibble_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst4, rst1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl_if #(.NIB(4)) bus4 ();
  nibble_serial_addsub_ctrl_if #(.NIB(1)) bus1 ();

  nibble_serial_addsub_ctrl #(.NIB(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
  nibble_serial_addsub_ctrl #(.NIB(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

  logic [15:0] exp_res4;
  logic        exp_c4, exp_v4;
  logic [3:0]  exp_res1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on W-bit words.
  task automatic model(input int nib, input bit op, input longint a, input longint b,
                       output longint r, output bit c, output bit v);
    longint m, sa, sb, rs;
    m  = longint'(1) << (4 * nib);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!op) begin
      r  = (a + b) % m;
      c  = (a + b) >= m;
      rs = sa + sb;
    end else begin
      r  = (a - b + m) % m;
      c  = a >= b;
      rs = sa - sb;
    end
    v = (rs >= m / 2) || (rs < -(m / 2));
  endtask

  // Called at posedge+1 in a cycle where start may be accepted (IDLE or DONE).
  // Returns at posedge+1 of the done cycle.
  task automatic run4(input bit op, input logic [15:0] a, input logic [15:0] b, input bit midstart);
    longint r; bit c, v;
    logic [15:0] prev;
    model(4, op, longint'(a), longint'(b), r, c, v);
    prev = exp_res4;
    bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("run4 busy k%0d", k), 32'(bus4.busy), 32'd1);
      check($sformatf("run4 done k%0d", k), 32'(bus4.done), 32'd0);
      check($sformatf("run4 hold k%0d", k), 32'(bus4.result), 32'(prev));
      if (midstart && k == 2) begin
        bus4.start = 1'b1; bus4.a = 16'hFFFF; bus4.b = 16'h1234; bus4.op = ~op;
      end
      @(posedge clk); #1;
      bus4.start = 1'b0;
    end
    exp_res4 = r[15:0]; exp_c4 = c; exp_v4 = v;
    check("run4 done", 32'(bus4.done), 32'd1);
    check("run4 busy_end", 32'(bus4.busy), 32'd0);
    check($sformatf("run4 result %0d %h %h", op, a, b), 32'(bus4.result), 32'(exp_res4));
    check($sformatf("run4 carry %0d %h %h", op, a, b), 32'(bus4.carry_out), 32'(exp_c4));
    check($sformatf("run4 ovf %0d %h %h", op, a, b), 32'(bus4.overflow), 32'(exp_v4));
  endtask

  task automatic idle4(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("idle4 done", 32'(bus4.done), 32'd0);
      check("idle4 busy", 32'(bus4.busy), 32'd0);
      check("idle4 result", 32'(bus4.result), 32'(exp_res4));
    end
  endtask

  task automatic run1(input bit op, input logic [3:0] a, input logic [3:0] b);
    longint r; bit c, v;
    model(1, op, longint'(a), longint'(b), r, c, v);
    bus1.start = 1'b1; bus1.op = op; bus1.a = a; bus1.b = b;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    check("run1 busy", 32'(bus1.busy), 32'd1);
    check("run1 hold", 32'(bus1.result), 32'(exp_res1));
    @(posedge clk); #1;
    exp_res1 = r[3:0];
    check("run1 done", 32'(bus1.done), 32'd1);
    check($sformatf("run1 result %0d %h %h", op, a, b), 32'(bus1.result), 32'(exp_res1));
    check($sformatf("run1 carry %0d %h %h", op, a, b), 32'(bus1.carry_out), 32'(c));
    check($sformatf("run1 ovf %0d %h %h", op, a, b), 32'(bus1.overflow), 32'(v));
  endtask

  initial begin
    rst4 = 1'b1; rst1 = 1'b1;
    bus4.start = 1'b0; bus4.op = 1'b0; bus4.a = '0; bus4.b = '0;
    bus1.start = 1'b0; bus1.op = 1'b0; bus1.a = '0; bus1.b = '0;
    exp_res4 = '0; exp_c4 = 1'b0; exp_v4 = 1'b0; exp_res1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus4.busy), 32'd0);
    check("reset done", 32'(bus4.done), 32'd0);
    check("reset result", 32'(bus4.result), 32'd0);
    check("reset carry", 32'(bus4.carry_out), 32'd0);
    check("reset ovf", 32'(bus4.overflow), 32'd0);
    check("reset1 result", 32'(bus1.result), 32'd0);
    rst4 = 1'b0; rst1 = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run4(1'b0, 16'h1234, 16'h0FFF, 1'b0); idle4(1);
    check("t1 result", 32'(bus4.result), 32'h2233);
    run4(1'b1, 16'h0005, 16'h0007, 1'b0); idle4(1);
    check("t2 result", 32'(bus4.result), 32'hFFFE);
    run4(1'b0, 16'h7FFF, 16'h0001, 1'b0); idle4(1);
    check("t3a ovf", 32'(bus4.overflow), 32'd1);
    run4(1'b0, 16'hFFFF, 16'h0001, 1'b0); idle4(1);
    check("t3b carry", 32'(bus4.carry_out), 32'd1);
    run4(1'b0, 16'h1111, 16'h2222, 1'b1);
    check("t4 result", 32'(bus4.result), 32'h3333);
    run4(1'b1, 16'h0001, 16'h0001, 1'b0);
    check("t4b carry", 32'(bus4.carry_out), 32'd1);
    idle4(2);

    // Randomized, mixing idle gaps and back-to-back starts in DONE
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
      run4(1'($urandom), ra, rb, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle4(1 + $urandom_range(0, 2));
    end
    idle4(1);

    // Reset in RUN cycle 2 aborts with no done pulse
    run4(1'b0, 16'h4321, 16'h1111, 1'b0);
    bus4.start = 1'b1; bus4.op = 1'b1; bus4.a = 16'h9ABC; bus4.b = 16'h1357;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    exp_res4 = '0;
    check("rst busy", 32'(bus4.busy), 32'd0);
    check("rst done", 32'(bus4.done), 32'd0);
    check("rst result", 32'(bus4.result), 32'd0);
    check("rst carry", 32'(bus4.carry_out), 32'd0);
    check("rst ovf", 32'(bus4.overflow), 32'd0);
    idle4(6);

    // NIB=1
    run1(1'b1, 4'h7, 4'h8);
    check("t6 result", 32'(bus1.result), 32'hF);
    for (int i = 0; i < 20; i++) begin
      run1(1'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
